// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, state encoding and queue entry type for the fetch unit
package fetch_pkg;
  localparam int PC_W = 64;
  localparam int INST_W = 32;
  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, FLUSH = 2'd2} state_t;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: imem request/response channels plus the datapath instruction and redirect channels
interface fetch_if;
  import fetch_pkg::*;
  logic imem_req_valid;
  logic imem_req_ready;
  logic [PC_W-1:0] imem_addr;
  logic imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic inst_valid;
  logic inst_ready;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0] inst_pc;
  logic redirect;
  logic [PC_W-1:0] redirect_pc;
  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    input imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect, redirect_pc
  );
  modport slave (
    input imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous fall-through FIFO of {pc, inst} with flush; head reads as zero when empty
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    count = wr_q - rd_q;
    rdata = empty ? '0 : mem_q[rd_q[AW-1:0]];
    wr_d = flush ? '0 : wr_q + (AW+1)'(push);
    rd_d = flush ? '0 : rd_q + (AW+1)'(pop && !empty);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, request credits, stale-response dropping and redirect FSM in front of fetch_queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'd10,
  parameter int QDEPTH = 2,
  parameter int MAX_OUT = 2
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);
  localparam int CW = $clog2(QDEPTH) + 1;
  state_t state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
  logic [CW:0] used;
  logic full, empty, acc, push, pop;
  fetch_entry_t wdata, rdata;
  always_comb begin
    pop = !empty && bus.inst_ready && !bus.redirect;
    // a head popped this edge frees its slot for a request issued in the same cycle
    used = (CW+1)'(count) - (CW+1)'(pop) + (CW+1)'(out_q);
    bus.imem_req_valid = state_q == FETCH && out_q < CW'(MAX_OUT) && used < (CW+1)'(QDEPTH) && !bus.redirect;
    bus.imem_addr = fetch_pc_q;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    push = bus.imem_rsp_valid && drop_q == '0 && !bus.redirect;
    wdata = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};
    bus.inst_valid = !empty;
    bus.inst = rdata.inst;
    bus.inst_pc = rdata.pc;
    out_d = out_q + CW'(acc) - CW'(bus.imem_rsp_valid);
    fetch_pc_d = bus.redirect ? bus.redirect_pc : fetch_pc_q + PC_W'(acc);
    rsp_pc_d = bus.redirect ? bus.redirect_pc : rsp_pc_q + PC_W'(push);
    drop_d = bus.redirect ? out_d : drop_q - CW'(bus.imem_rsp_valid && drop_q != '0);
    state_d = state_q == BOOT  ? FETCH :
              state_q == FETCH ? (bus.redirect && out_d != '0 ? FLUSH : FETCH) :
              (!bus.redirect && drop_d == '0 ? FETCH : FLUSH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  end
  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(bus.redirect),
    .wdata(wdata),
    .rdata(rdata),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios against an in-order latency-programmable memory model
module tb_fetch_unit;
  import fetch_pkg::*;
  typedef struct {
    logic [63:0] a;
    int due;
  } req_t;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat = 1;
  req_t mq[$];
  fetch_if bus();
  fetch_unit #(.RESET_PC(64'd10), .QDEPTH(2), .MAX_OUT(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    bit r;
    @(negedge clk);
    r = rst;
    if (!r && bus.imem_req_valid && bus.imem_req_ready) mq.push_back('{bus.imem_addr, cyc + lat});
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      mq.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = 32'h0;
    end else begin
      if (bus.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
      bus.imem_rsp_valid = mq.size() > 0 && mq[0].due <= cyc;
      bus.imem_rsp_data = bus.imem_rsp_valid ? {16'hC0DE, mq[0].a[15:0]} : 32'h0;
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 64'h0;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    bus.inst_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 64'h0;
    // zero-wait memory, consumer always ready
    do_reset();
    chk("rst req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst addr", bus.imem_addr, 64'd10);
    chk("rst inst", 64'(bus.inst), 64'd0);
    chk("rst inst_pc", bus.inst_pc, 64'd0);
    chk("rst state", 64'(dut.state_q), 64'(BOOT));
    tick();
    chk("s1 rv0", 64'(bus.imem_req_valid), 64'd1);
    chk("s1 addr10", bus.imem_addr, 64'd10);
    tick();
    chk("s1 addr11", bus.imem_addr, 64'd11);
    chk("s1 no bypass", 64'(bus.inst_valid), 64'd0);
    tick();
    chk("s1 first valid", 64'(bus.inst_valid), 64'd1);
    chk("s1 first pc", bus.inst_pc, 64'd10);
    chk("s1 first inst", 64'(bus.inst), 64'hC0DE000A);
    chk("s1 addr12", bus.imem_addr, 64'd12);
    chk("s1 rv steady", 64'(bus.imem_req_valid), 64'd1);
    tick();
    chk("s1 pc11", bus.inst_pc, 64'd11);
    chk("s1 addr13", bus.imem_addr, 64'd13);
    tick();
    chk("s1 pc12 valid", 64'(bus.inst_valid), 64'd1);
    chk("s1 pc12", bus.inst_pc, 64'd12);
    // consumer stalled: only QDEPTH requests may be issued
    do_reset();
    bus.inst_ready = 1'b0;
    tick();
    chk("s2 addr10", bus.imem_addr, 64'd10);
    tick();
    chk("s2 addr11", bus.imem_addr, 64'd11);
    tick();
    chk("s2 credit stop", 64'(bus.imem_req_valid), 64'd0);
    chk("s2 head pc10", bus.inst_pc, 64'd10);
    tick();
    chk("s2 still stopped", 64'(bus.imem_req_valid), 64'd0);
    chk("s2 addr held", bus.imem_addr, 64'd12);
    bus.inst_ready = 1'b1;
    #1;
    chk("s2 resume rv", 64'(bus.imem_req_valid), 64'd1);
    tick();
    chk("s2 head pc11", bus.inst_pc, 64'd11);
    tick();
    chk("s2 head pc12", bus.inst_pc, 64'd12);
    // memory not ready for 5 cycles
    do_reset();
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("s3 rv held", 64'(bus.imem_req_valid), 64'd1);
    chk("s3 addr held", bus.imem_addr, 64'd10);
    bus.imem_req_ready = 1'b1;
    tick();
    chk("s3 addr11", bus.imem_addr, 64'd11);
    tick();
    chk("s3 pc10", bus.inst_pc, 64'd10);
    chk("s3 inst", 64'(bus.inst), 64'hC0DE000A);
    // redirect with two requests in flight, 3-cycle memory
    do_reset();
    lat = 3;
    tick();
    chk("s4 addr10", bus.imem_addr, 64'd10);
    tick();
    chk("s4 addr11", bus.imem_addr, 64'd11);
    tick();
    chk("s4 out stall", 64'(bus.imem_req_valid), 64'd0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'd24;
    tick();
    bus.redirect = 1'b0;
    chk("s4 flush state", 64'(dut.state_q), 64'(FLUSH));
    chk("s4 iv0 after redirect", 64'(bus.inst_valid), 64'd0);
    tick();
    chk("s4 drop1 iv", 64'(bus.inst_valid), 64'd0);
    chk("s4 still flush", 64'(dut.state_q), 64'(FLUSH));
    tick();
    chk("s4 back to fetch", 64'(dut.state_q), 64'(FETCH));
    chk("s4 rv", 64'(bus.imem_req_valid), 64'd1);
    chk("s4 addr24", bus.imem_addr, 64'd24);
    tick();
    chk("s4 addr25", bus.imem_addr, 64'd25);
    tick();
    tick();
    chk("s4 no stale", 64'(bus.inst_valid), 64'd0);
    tick();
    chk("s4 iv", 64'(bus.inst_valid), 64'd1);
    chk("s4 pc24", bus.inst_pc, 64'd24);
    chk("s4 inst24", 64'(bus.inst), 64'hC0DE0018);
    // redirect while idle with a full queue
    do_reset();
    lat = 1;
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("s5 full head", bus.inst_pc, 64'd10);
    chk("s5 idle", 64'(bus.imem_req_valid), 64'd0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'd40;
    bus.inst_ready = 1'b1;
    #1;
    chk("s5 no req on redirect", 64'(bus.imem_req_valid), 64'd0);
    tick();
    bus.redirect = 1'b0;
    chk("s5 flushed", 64'(bus.inst_valid), 64'd0);
    chk("s5 no flush state", 64'(dut.state_q), 64'(FETCH));
    chk("s5 addr40", bus.imem_addr, 64'd40);
    tick();
    chk("s5 addr41", bus.imem_addr, 64'd41);
    tick();
    chk("s5 pc40", bus.inst_pc, 64'd40);
    chk("s5 inst40", 64'(bus.inst), 64'hC0DE0028);
    // reset with a request in flight and a queued entry
    do_reset();
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("s6 queued", 64'(bus.inst_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6 rv", 64'(bus.imem_req_valid), 64'd0);
    chk("s6 iv", 64'(bus.inst_valid), 64'd0);
    chk("s6 addr", bus.imem_addr, 64'd10);
    chk("s6 inst", 64'(bus.inst), 64'd0);
    chk("s6 pc", bus.inst_pc, 64'd0);
    bus.inst_ready = 1'b1;
    tick();
    chk("s6 restart addr", bus.imem_addr, 64'd10);
    chk("s6 restart rv", 64'(bus.imem_req_valid), 64'd1);
    tick();
    chk("s6 no stale", 64'(bus.inst_valid), 64'd0);
    tick();
    chk("s6 pc10", bus.inst_pc, 64'd10);
    chk("s6 inst10", 64'(bus.inst), 64'hC0DE000A);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
